// File: rtl/branch_sequencer.sv
// Control-flow sequencer: decodes branch micro-ops and drives the PC jump inputs.
// Also owns the return-address stack, the post-redirect flush window and the halt/fault state.
module branch_sequencer #(
    parameter int STACK_DEPTH  = 8,
    parameter int FLUSH_CYCLES = 1,
    parameter int ADDR_W       = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         op_valid,
    input  logic [2:0]                   op,
    input  logic [ADDR_W-1:0]            target,
    input  logic [ADDR_W-1:0]            pc,
    input  logic                         zero_flag,
    output logic                         jmp_en,
    output logic [ADDR_W-1:0]            jmp_addr,
    output logic                         flush,
    output logic                         halted,
    output logic [1:0]                   err,
    output logic [$clog2(STACK_DEPTH):0] sp
);

    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam int SP_W  = IDX_W + 1;

    localparam logic [2:0] OP_JMP  = 3'd1;
    localparam logic [2:0] OP_JZ   = 3'd2;
    localparam logic [2:0] OP_JNZ  = 3'd3;
    localparam logic [2:0] OP_CALL = 3'd4;
    localparam logic [2:0] OP_RET  = 3'd5;
    localparam logic [2:0] OP_HALT = 3'd6;

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_OVF  = 2'd1;
    localparam logic [1:0] ERR_UNF  = 2'd2;

    localparam logic [SP_W-1:0] SP_FULL    = SP_W'(STACK_DEPTH);
    localparam logic [3:0]      FLUSH_LOAD = 4'(FLUSH_CYCLES);
    localparam bit              HAS_FLUSH  = (FLUSH_CYCLES != 0);

    logic [1:0]        state, state_nx;
    logic [3:0]        flush_cnt, flush_cnt_nx;
    logic [SP_W-1:0]   sp_nx;
    logic [1:0]        err_q, fault;
    logic              push, redirect;
    logic [IDX_W-1:0]  push_idx, pop_idx;
    logic [ADDR_W-1:0] ret_addr;

    logic [ADDR_W-1:0] stack [STACK_DEPTH];

    assign push_idx = IDX_W'(sp);
    assign pop_idx  = IDX_W'(sp - SP_W'(1));
    assign ret_addr = pc + ADDR_W'(1);

    // NOTE: every signal written here gets a default first so no path can infer a latch.
    always_comb begin
        jmp_en       = 1'b0;
        jmp_addr     = '0;
        state_nx     = state;
        flush_cnt_nx = flush_cnt;
        sp_nx        = sp;
        fault        = ERR_NONE;
        push         = 1'b0;
        redirect     = 1'b0;
        if (!rst) begin
            case (state)
                ST_RUN: begin
                    if (op_valid) begin
                        case (op)
                            OP_JMP:  redirect = 1'b1;
                            OP_JZ:   redirect = zero_flag;
                            OP_JNZ:  redirect = !zero_flag;
                            OP_CALL: begin
                                if (sp != SP_FULL) begin
                                    push     = 1'b1;
                                    sp_nx    = sp + SP_W'(1);
                                    redirect = 1'b1;
                                end else begin
                                    fault    = ERR_OVF;
                                    state_nx = ST_HALT;
                                end
                            end
                            OP_RET: begin
                                if (sp != '0) begin
                                    sp_nx    = sp - SP_W'(1);
                                    redirect = 1'b1;
                                end else begin
                                    fault    = ERR_UNF;
                                    state_nx = ST_HALT;
                                end
                            end
                            OP_HALT: begin
                                jmp_en   = 1'b1;
                                jmp_addr = pc;
                                state_nx = ST_HALT;
                            end
                            default: ;
                        endcase
                        if (redirect) begin
                            jmp_en   = 1'b1;
                            jmp_addr = (op == OP_RET) ? stack[pop_idx] : target;
                            if (HAS_FLUSH) begin
                                state_nx     = ST_FLUSH;
                                flush_cnt_nx = FLUSH_LOAD;
                            end
                        end
                    end
                end
                ST_FLUSH: begin
                    // Counter holds the flush cycles still owed, including this one.
                    if (flush_cnt <= 4'd1) begin
                        state_nx     = ST_RUN;
                        flush_cnt_nx = '0;
                    end else begin
                        flush_cnt_nx = flush_cnt - 4'd1;
                    end
                end
                ST_HALT: begin
                    jmp_en   = 1'b1;
                    jmp_addr = pc;
                end
                default: state_nx = ST_RUN;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_RUN;
            flush_cnt <= '0;
            sp        <= '0;
            err_q     <= ERR_NONE;
        end else begin
            state     <= state_nx;
            flush_cnt <= flush_cnt_nx;
            sp        <= sp_nx;
            if (err_q == ERR_NONE)
                err_q <= fault;
        end
    end

    // NOTE: stack storage is deliberately not reset; sp alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (push)
            stack[push_idx] <= ret_addr;
    end

    assign flush  = (state == ST_FLUSH);
    assign halted = (state == ST_HALT);
    assign err    = err_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench for branch_sequencer: two instances (flush window 1 and 3) share stimulus.
// Directed table, hand-written corner sequences and random ops, all checked against a queue-free array model.
module tb_branch_sequencer;

    localparam int DEPTH = 8;
    localparam logic [2:0] NOP = 3'd0, JMP = 3'd1, JZ = 3'd2, JNZ = 3'd3,
                           CALL = 3'd4, RET = 3'd5, HLT = 3'd6;

    logic        clk = 1'b0;
    logic        rst, op_valid, zero_flag;
    logic [2:0]  op;
    logic [15:0] target, pc;

    logic        en1, flush1, halt1, en3, flush3, halt3;
    logic [15:0] addr1, addr3;
    logic [1:0]  err1, err3;
    logic [3:0]  sp1, sp3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_sequencer #(.STACK_DEPTH(DEPTH), .FLUSH_CYCLES(1), .ADDR_W(16)) u_dut1 (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .target(target), .pc(pc),
        .zero_flag(zero_flag), .jmp_en(en1), .jmp_addr(addr1), .flush(flush1),
        .halted(halt1), .err(err1), .sp(sp1));

    branch_sequencer #(.STACK_DEPTH(DEPTH), .FLUSH_CYCLES(3), .ADDR_W(16)) u_dut3 (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .target(target), .pc(pc),
        .zero_flag(zero_flag), .jmp_en(en3), .jmp_addr(addr3), .flush(flush3),
        .halted(halt3), .err(err3), .sp(sp3));

    // Reference model: per instance halt flag, flush cycles owed, sticky error, return stack.
    int          m_fc   [2] = '{1, 3};
    bit          m_halt [2];
    int          m_flush[2];
    int          m_err  [2];
    int          m_sp   [2];
    logic [15:0] m_stk  [2][DEPTH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [2:0] o,
                         input logic [15:0] t, input logic [15:0] p, input logic z);
        rst = r; op_valid = v; op = o; target = t; pc = p; zero_flag = z;
    endtask

    task automatic model_jump(input int k, output logic e_en, output logic [15:0] e_addr);
        e_en = 1'b0;
        e_addr = 16'h0;
        if (rst) begin
            e_en = 1'b0;
        end else if (m_halt[k]) begin
            e_en = 1'b1; e_addr = pc;
        end else if (m_flush[k] == 0 && op_valid) begin
            case (op)
                JMP: begin e_en = 1'b1; e_addr = target; end
                JZ:  begin e_en = zero_flag;  e_addr = target; end
                JNZ: begin e_en = !zero_flag; e_addr = target; end
                CALL: if (m_sp[k] < DEPTH) begin e_en = 1'b1; e_addr = target; end
                RET:  if (m_sp[k] > 0) begin e_en = 1'b1; e_addr = m_stk[k][m_sp[k]-1]; end
                HLT:  begin e_en = 1'b1; e_addr = pc; end
                default: ;
            endcase
        end
    endtask

    task automatic check_model();
        logic        e_en;
        logic [15:0] e_addr;
        string       tag;
        for (int k = 0; k < 2; k++) begin
            tag = (k == 0) ? "d1" : "d3";
            model_jump(k, e_en, e_addr);
            check({tag, ".jmp_en"}, (k == 0) ? en1 : en3, e_en);
            if (e_en || rst)
                check({tag, ".jmp_addr"}, (k == 0) ? addr1 : addr3, e_addr);
            check({tag, ".flush"},  (k == 0) ? flush1 : flush3, m_flush[k] > 0);
            check({tag, ".halted"}, (k == 0) ? halt1 : halt3, m_halt[k]);
            check({tag, ".err"},    (k == 0) ? err1 : err3, m_err[k]);
            check({tag, ".sp"},     (k == 0) ? sp1 : sp3, m_sp[k]);
        end
    endtask

    task automatic step_model();
        bit redirect;
        for (int k = 0; k < 2; k++) begin
            redirect = 1'b0;
            if (rst) begin
                m_halt[k] = 1'b0; m_flush[k] = 0; m_err[k] = 0; m_sp[k] = 0;
            end else if (m_halt[k]) begin
                m_halt[k] = 1'b1;
            end else if (m_flush[k] > 0) begin
                m_flush[k]--;
            end else if (op_valid) begin
                case (op)
                    JMP: redirect = 1'b1;
                    JZ:  redirect = zero_flag;
                    JNZ: redirect = !zero_flag;
                    CALL: if (m_sp[k] < DEPTH) begin
                        m_stk[k][m_sp[k]] = pc + 16'd1;
                        m_sp[k]++;
                        redirect = 1'b1;
                    end else begin
                        m_err[k] = 1; m_halt[k] = 1'b1;
                    end
                    RET: if (m_sp[k] > 0) begin
                        m_sp[k]--;
                        redirect = 1'b1;
                    end else begin
                        m_err[k] = 2; m_halt[k] = 1'b1;
                    end
                    HLT: m_halt[k] = 1'b1;
                    default: ;
                endcase
                if (redirect)
                    m_flush[k] = m_fc[k];
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        step_model();
        #1;
    endtask

    task automatic apply(input logic r, input logic v, input logic [2:0] o,
                         input logic [15:0] t, input logic [15:0] p, input logic z);
        drive(r, v, o, t, p, z);
        @(negedge clk);
        check_model();
        tick();
    endtask

    typedef struct {
        logic r; logic v; logic [2:0] o; logic [15:0] t; logic [15:0] p; logic z;
        logic e_en; logic [15:0] e_addr; logic e_flush; logic e_halt; logic [1:0] e_err; logic [3:0] e_sp;
    } vec_t;

    vec_t tbl[26];

    initial begin
        //            r  v  op   target    pc        z     en a         fl h  err sp   (flush-1 instance)
        tbl[0]  = '{1, 0, NOP,  16'h0000, 16'h0000, 0,    0, 16'h0000, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, JMP,  16'h0040, 16'h0000, 0,    1, 16'h0040, 0, 0, 0, 0};
        tbl[2]  = '{0, 1, JMP,  16'h0080, 16'h0040, 0,    0, 16'h0000, 1, 0, 0, 0};
        tbl[3]  = '{0, 0, NOP,  16'h0000, 16'h0041, 0,    0, 16'h0000, 0, 0, 0, 0};
        tbl[4]  = '{0, 1, JZ,   16'h0100, 16'h0042, 1,    1, 16'h0100, 0, 0, 0, 0};
        tbl[5]  = '{0, 0, NOP,  16'h0000, 16'h0100, 0,    0, 16'h0000, 1, 0, 0, 0};
        tbl[6]  = '{0, 1, JZ,   16'h0100, 16'h0101, 0,    0, 16'h0000, 0, 0, 0, 0};
        tbl[7]  = '{0, 1, JNZ,  16'h0120, 16'h0102, 0,    1, 16'h0120, 0, 0, 0, 0};
        tbl[8]  = '{0, 0, NOP,  16'h0000, 16'h0120, 0,    0, 16'h0000, 1, 0, 0, 0};
        tbl[9]  = '{0, 1, CALL, 16'h0200, 16'h0010, 0,    1, 16'h0200, 0, 0, 0, 0};
        tbl[10] = '{0, 0, NOP,  16'h0000, 16'h0200, 0,    0, 16'h0000, 1, 0, 0, 1};
        tbl[11] = '{0, 1, CALL, 16'h0300, 16'h0205, 0,    1, 16'h0300, 0, 0, 0, 1};
        tbl[12] = '{0, 0, NOP,  16'h0000, 16'h0300, 0,    0, 16'h0000, 1, 0, 0, 2};
        tbl[13] = '{0, 1, RET,  16'h0000, 16'h0301, 0,    1, 16'h0206, 0, 0, 0, 2};
        tbl[14] = '{0, 0, NOP,  16'h0000, 16'h0206, 0,    0, 16'h0000, 1, 0, 0, 1};
        tbl[15] = '{0, 1, RET,  16'h0000, 16'h0207, 0,    1, 16'h0011, 0, 0, 0, 1};
        tbl[16] = '{0, 0, NOP,  16'h0000, 16'h0011, 0,    0, 16'h0000, 1, 0, 0, 0};
        tbl[17] = '{0, 1, CALL, 16'h0500, 16'hFFFF, 0,    1, 16'h0500, 0, 0, 0, 0};
        tbl[18] = '{0, 0, NOP,  16'h0000, 16'h0500, 0,    0, 16'h0000, 1, 0, 0, 1};
        tbl[19] = '{0, 1, RET,  16'h0000, 16'h0501, 0,    1, 16'h0000, 0, 0, 0, 1};
        tbl[20] = '{0, 0, NOP,  16'h0000, 16'h0000, 0,    0, 16'h0000, 1, 0, 0, 0};
        tbl[21] = '{0, 1, RET,  16'h0000, 16'h0001, 0,    0, 16'h0000, 0, 0, 0, 0};
        tbl[22] = '{0, 0, NOP,  16'h0000, 16'h0002, 0,    1, 16'h0002, 0, 1, 2, 0};
        tbl[23] = '{0, 1, JMP,  16'h0700, 16'h0003, 0,    1, 16'h0003, 0, 1, 2, 0};
        tbl[24] = '{1, 0, NOP,  16'h0000, 16'h0004, 0,    0, 16'h0000, 0, 1, 2, 0};
        tbl[25] = '{0, 0, NOP,  16'h0000, 16'h0000, 0,    0, 16'h0000, 0, 0, 0, 0};

        drive(1, 0, NOP, 16'h0, 16'h0, 0);
        @(posedge clk);
        @(posedge clk);
        step_model();
        #1;

        // Directed table against the flush-1 instance, plus the model for both.
        for (int i = 0; i < 26; i++) begin
            drive(tbl[i].r, tbl[i].v, tbl[i].o, tbl[i].t, tbl[i].p, tbl[i].z);
            @(negedge clk);
            check_model();
            check($sformatf("tbl%0d.jmp_en", i), en1, tbl[i].e_en);
            if (tbl[i].e_en || tbl[i].r)
                check($sformatf("tbl%0d.jmp_addr", i), addr1, tbl[i].e_addr);
            check($sformatf("tbl%0d.flush", i), flush1, tbl[i].e_flush);
            check($sformatf("tbl%0d.halted", i), halt1, tbl[i].e_halt);
            check($sformatf("tbl%0d.err", i), err1, tbl[i].e_err);
            check($sformatf("tbl%0d.sp", i), sp1, tbl[i].e_sp);
            tick();
        end

        // Nine CALLs: the ninth overflows and freezes the PC.
        apply(1, 0, NOP, 16'h0, 16'h0, 0);
        for (int i = 0; i < 9; i++) begin
            apply(0, 1, CALL, 16'h2000 + 16'(i), 16'h1000 + 16'(i), 0);
            for (int j = 0; j < 3; j++)
                apply(0, 0, NOP, 16'h0, 16'h2000 + 16'(i), 0);
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 3'(i), 16'h4444, 16'h3330 + 16'(i), 1);
            @(negedge clk);
            check_model();
            check("ovf.halted", halt1, 1'b1);
            check("ovf.err", err1, 2'd1);
            check("ovf.sp", sp1, 4'd8);
            check("ovf.jmp_en", en1, 1'b1);
            check("ovf.jmp_addr", addr1, 16'h3330 + 16'(i));
            tick();
        end

        // Reset in HALT returns to RUN with an empty stack.
        apply(1, 1, JMP, 16'h0, 16'h5555, 0);
        drive(0, 0, NOP, 16'h0, 16'h5556, 0);
        @(negedge clk);
        check_model();
        check("rsthalt.state", {halt3, flush3, halt1, flush1}, 4'b0000);
        check("rsthalt.err_sp", {err1, sp1}, 6'd0);
        check("rsthalt.jmp_en", {en1, en3}, 2'b00);
        tick();

        // RET on an empty stack faults with underflow.
        apply(0, 1, RET, 16'h0, 16'h0060, 0);
        drive(0, 0, NOP, 16'h0, 16'h0061, 0);
        @(negedge clk);
        check_model();
        check("unf.err", err1, 2'd2);
        check("unf.halted", halt1, 1'b1);
        tick();

        // Reset mid-flush on the three-cycle instance.
        apply(1, 0, NOP, 16'h0, 16'h0, 0);
        apply(0, 1, CALL, 16'h0090, 16'h0050, 0);
        drive(1, 0, NOP, 16'h0, 16'h0090, 0);
        @(negedge clk);
        check_model();
        check("rstflush.pre", flush3, 1'b1);
        tick();
        drive(0, 0, NOP, 16'h0, 16'h0091, 0);
        @(negedge clk);
        check_model();
        check("rstflush.flush", flush3, 1'b0);
        check("rstflush.sp", sp3, 4'd0);
        check("rstflush.jmp_en", en3, 1'b0);
        tick();

        // Random ops with occasional resets, checked only against the model.
        for (int n = 0; n < 3000; n++) begin
            logic [2:0] o;
            o = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0)
                o = ($urandom_range(0, 2) == 0) ? RET : CALL;
            apply($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, o,
                  16'($urandom), ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom),
                  1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
